time_dmr_end: RTL and testbench
===============================

# time_dmr_end

Checker half of the time-redundant (DMR) pipeline. Sits downstream of `time_DMR_start`, which issues every item twice with the same ID, and upstream of `retry_end`. Pairs consecutive copies by ID and compares their data. Forwards each completed pair once, marked either clean or needs-retry, so `retry_end` can send the ID back to `retry_start` for re-issue.

## Interface
- `DataType`, default `logic`: payload type.
- `IDSize`, default 1: ID width in bits.
- `LockTimeout`, default 4: cycles to wait for a second copy before abandoning the first.
- `InternalRedundancy`, default 0: when 1, state, timeout counter and output-valid registers are triplicated and majority-voted every cycle.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `enable_i`  in  1  1 = redundancy checking, 0 = pass-through
- `next_id_i`  in  IDSize  ID that the start stage will assign next
- `data_i`  in  DataType  upstream payload
- `id_i`  in  IDSize  upstream ID
- `valid_i`  in  1  upstream valid
- `ready_o`  out  1  upstream ready
- `data_o`  out  DataType  downstream payload
- `id_o`  out  IDSize  downstream ID
- `needs_retry_o`  out  1  item failed checking; downstream must retry it
- `valid_o`  out  1  downstream valid
- `ready_i`  in  1  downstream ready
- `lock_o`  out  1  high while holding an unpaired first copy
- `fault_detected_o`  out  1  one-cycle pulse per detected fault

## Operation
**Pass-through (`enable_i` = 0)**
- Combinational path: `data_o`=`data_i`, `id_o`=`id_i`, `valid_o`=`valid_i`, `ready_o`=`ready_i`.
- `needs_retry_o`=0, `lock_o`=0, `fault_detected_o`=0.
- FSM is held in BASE and the output register is cleared. Any pending first copy is dropped.

**Checking (`enable_i` = 1)** uses two storage elements:
- holding register A: data and ID;
- output register O: valid, data, id, needs_retry. O drives the outputs.

Handshake rules:
- A transfer occurs on `valid_i` & `ready_o`.
- `ready_o` = !O.valid | `ready_i`, i.e. O is empty or draining this cycle.

FSM states and transitions:
- **BASE**: on transfer, if `id_i` == `next_id_i`, the ID has not been issued yet. Discard the item and pulse `fault_detected_o`. Otherwise store the item in A, clear the counter, and go to WAIT.
- **WAIT** (`lock_o`=1):
  - Transfer with `id_i` == A.id: load O with A.data and A.id, needs_retry = (`data_i` != A.data). Go to BASE.
  - Transfer with `id_i` != A.id: load O with A.data and A.id, needs_retry=1. Store the new item in A, clear the counter, stay in WAIT.
  - Cycle with no transfer: counter increments. When the counter reaches `LockTimeout`, load O with A, needs_retry=1, and go to BASE. If O is still full at that point, the timeout action waits until O frees.
- `fault_detected_o` is registered. It is high for one cycle for each O load with needs_retry=1, and for each discard.
- O is cleared on `valid_o` & `ready_i` unless it is reloaded in the same cycle.
- While `valid_o`=1 and `ready_i`=0, `data_o`, `id_o` and `needs_retry_o` hold stable.
- ID comparisons and `next_id_i` are modulo 2^IDSize.

## Timing
- Reset (asynchronous, `rst_ni`=0): FSM in BASE, counter 0, O cleared.
  - Reset values: `valid_o`=0, `needs_retry_o`=0, `data_o`=0, `id_o`=0, `lock_o`=0, `fault_detected_o`=0.
  - `ready_o`=0 while `rst_ni`=0.
- Checking-mode latency: `valid_o` rises the cycle after the second-copy transfer.
- Timeout: the first copy is accepted at cycle T. With no further transfers, `valid_o`=1 with needs_retry at cycle T+`LockTimeout`+1.
- Reset mid-pair: the pending copy and O are lost; no output is produced.
- Toggling `enable_i` takes effect at the next clock edge. The cycle in which it toggles behaves according to its new value combinationally.

## Test plan
- `enable_i`=0; drive `data_i`=0xA5, `id_i`=3, `valid_i`=1, `ready_i`=1 → in the same cycle `valid_o`=1, `data_o`=0xA5, `id_o`=3, `needs_retry_o`=0.
- `enable_i`=1, `next_id_i`=3; send two consecutive copies {0x3C, id 2} → the next cycle `valid_o`=1, `data_o`=0x3C, `id_o`=2, `needs_retry_o`=0, `fault_detected_o`=0.
- Send copies {0x3C, id 2} then {0x3D, id 2} → `id_o`=2, `data_o`=0x3C, `needs_retry_o`=1, `fault_detected_o` pulses once.
- `LockTimeout`=4; send a single copy, id 5, then no valid → `lock_o`=1 for 4 cycles; on the 5th cycle `valid_o`=1, `id_o`=5, `needs_retry_o`=1.
- Send id 6, then id 7 twice → first output id 6 with needs_retry=1; then id 7 with needs_retry=0.
- With O full and `ready_i`=0 → `ready_o`=0 and outputs stable. Assert `rst_ni`=0 while in WAIT → `valid_o`=0 and `lock_o`=0 immediately; after reset releases, the next clean pair outputs normally.

Source files
------------

// File: rtl/time_dmr_end.sv
// Checker half of a time-redundant pipeline: pairs the two copies of each item by ID,
// compares their payloads and forwards one result per pair flagged clean or needs-retry.
module time_dmr_end #(
    parameter type         DataType           = logic,
    parameter int unsigned IDSize             = 1,
    parameter int unsigned LockTimeout        = 4,
    parameter bit          InternalRedundancy = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic [IDSize-1:0] next_id_i,
    input  DataType           data_i,
    input  logic [IDSize-1:0] id_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic [IDSize-1:0] id_o,
    output logic              needs_retry_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              lock_o,
    output logic              fault_detected_o
);

    typedef enum logic {BASE = 1'b0, WAIT = 1'b1} state_e;

    localparam int unsigned    NREP    = InternalRedundancy ? 3 : 1;
    localparam int unsigned    I1      = (NREP > 1) ? 1 : 0;
    localparam int unsigned    I2      = (NREP > 2) ? 2 : 0;
    localparam int unsigned    CW      = (LockTimeout > 1) ? $clog2(LockTimeout) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(LockTimeout - 1);

    // Handshake: an item moves upstream->here on valid_i & ready_o, and here->downstream on
    // valid_o & ready_i; valid never waits on ready, and payload holds while valid & !ready.

    // Replicated control registers (a single copy when redundancy is off)
    state_e        state_q [NREP];
    logic [CW-1:0] cnt_q   [NREP];
    logic          ov_q    [NREP];

    state_e        state_v, state_d;
    logic [CW-1:0] cnt_v, cnt_d;
    logic          ov_v, ov_d;

    DataType           a_data_q, a_data_d;
    logic [IDSize-1:0] a_id_q, a_id_d;
    DataType           od_q, od_d;
    logic [IDSize-1:0] oid_q, oid_d;
    logic              ort_q, ort_d;
    logic              fault_q, fault_d;

    logic o_free;
    logic xfer;
    logic retry;

    // Majority vote; with a single copy all three operands alias copy 0
    assign state_v = state_e'((state_q[0] & state_q[I1]) | (state_q[0] & state_q[I2]) |
                              (state_q[I1] & state_q[I2]));
    assign cnt_v   = (cnt_q[0] & cnt_q[I1]) | (cnt_q[0] & cnt_q[I2]) | (cnt_q[I1] & cnt_q[I2]);
    assign ov_v    = (ov_q[0] & ov_q[I1]) | (ov_q[0] & ov_q[I2]) | (ov_q[I1] & ov_q[I2]);

    assign o_free = !ov_v || ready_i;
    assign xfer   = valid_i && o_free;

    always_comb begin
        state_d  = state_v;
        cnt_d    = cnt_v;
        ov_d     = ov_v;
        a_data_d = a_data_q;
        a_id_d   = a_id_q;
        od_d     = od_q;
        oid_d    = oid_q;
        ort_d    = ort_q;
        fault_d  = 1'b0;
        retry    = 1'b0;
        if (!enable_i) begin
            state_d = BASE;
            cnt_d   = '0;
            ov_d    = 1'b0;
            od_d    = '0;
            oid_d   = '0;
            ort_d   = 1'b0;
        end else begin
            if (ov_v && ready_i) ov_d = 1'b0;
            case (state_v)
                BASE: begin
                    if (xfer) begin
                        // An ID equal to next_id_i has not been issued yet: stray item
                        if (id_i == next_id_i) begin
                            fault_d = 1'b1;
                        end else begin
                            a_data_d = data_i;
                            a_id_d   = id_i;
                            cnt_d    = '0;
                            state_d  = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (xfer) begin
                        ov_d  = 1'b1;
                        od_d  = a_data_q;
                        oid_d = a_id_q;
                        if (id_i == a_id_q) begin
                            retry   = (data_i != a_data_q);
                            state_d = BASE;
                        end else begin
                            retry    = 1'b1;
                            a_data_d = data_i;
                            a_id_d   = id_i;
                            cnt_d    = '0;
                        end
                        ort_d   = retry;
                        fault_d = retry;
                    end else if (cnt_v == CNT_MAX) begin
                        // Timed out; abandon the lone copy once O can take it
                        if (o_free) begin
                            ov_d    = 1'b1;
                            od_d    = a_data_q;
                            oid_d   = a_id_q;
                            ort_d   = 1'b1;
                            fault_d = 1'b1;
                            cnt_d   = '0;
                            state_d = BASE;
                        end
                    end else begin
                        cnt_d = cnt_v + 1'b1;
                    end
                end
                default: state_d = BASE;
            endcase
        end
    end

    for (genvar r = 0; r < NREP; r++) begin : g_rep
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q[r] <= BASE;
                cnt_q[r]   <= '0;
                ov_q[r]    <= 1'b0;
            end else begin
                state_q[r] <= state_d;
                cnt_q[r]   <= cnt_d;
                ov_q[r]    <= ov_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_data_q <= '0;
            a_id_q   <= '0;
            od_q     <= '0;
            oid_q    <= '0;
            ort_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            a_data_q <= a_data_d;
            a_id_q   <= a_id_d;
            od_q     <= od_d;
            oid_q    <= oid_d;
            ort_q    <= ort_d;
            fault_q  <= fault_d;
        end
    end

    assign ready_o          = rst_ni && (enable_i ? o_free : ready_i);
    assign valid_o          = enable_i ? ov_v : (rst_ni && valid_i);
    assign data_o           = enable_i ? od_q : data_i;
    assign id_o             = enable_i ? oid_q : id_i;
    assign needs_retry_o    = enable_i && ort_q;
    assign lock_o           = enable_i && (state_v == WAIT);
    assign fault_detected_o = enable_i && fault_q;

endmodule

// File: tb/tb_time_dmr_end.sv
// Bench for time_dmr_end: directed steps plus randomized item streams checked against
// a transaction-level pairing model.
module tb_time_dmr_end;

    localparam int LT = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       enable_i = 1'b1;
    logic [2:0] next_id_i = '0;
    logic [7:0] data_i = '0;
    logic [2:0] id_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_o;
    logic [2:0] id_o;
    logic       needs_retry_o;
    logic       valid_o;
    logic       ready_i = 1'b1;
    logic       lock_o;
    logic       fault_detected_o;

    time_dmr_end #(
        .DataType          (logic [7:0]),
        .IDSize            (3),
        .LockTimeout       (LT),
        .InternalRedundancy(1'b1)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .enable_i        (enable_i),
        .next_id_i       (next_id_i),
        .data_i          (data_i),
        .id_i            (id_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .data_o          (data_o),
        .id_o            (id_o),
        .needs_retry_o   (needs_retry_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .lock_o          (lock_o),
        .fault_detected_o(fault_detected_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one pending first copy plus an expected-output queue {retry, id, data}
    logic [11:0] exp_q[$];
    bit          model_on = 1'b0;
    bit          m_has;
    logic [2:0]  m_id;
    logic [7:0]  m_data;
    int          m_idle;
    bit          exp_valid, exp_fault, exp_lock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_has = 1'b0;
        m_idle = 0;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        exp_lock = 1'b0;
        exp_q.delete();
    endtask

    task automatic emit(input logic [2:0] id, input logic [7:0] d, input bit r);
        exp_q.push_back({r, id, d});
        exp_valid = 1'b1;
        exp_fault = r;
    endtask

    // Applies the pairing rules to the inputs about to be sampled (downstream always ready)
    task automatic model_step();
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        if (valid_i) begin
            if (!m_has) begin
                if (id_i == next_id_i) begin
                    exp_fault = 1'b1;
                end else begin
                    m_has = 1'b1;
                    m_id = id_i;
                    m_data = data_i;
                    m_idle = 0;
                end
            end else begin
                emit(m_id, m_data, (id_i != m_id) || (data_i != m_data));
                if (id_i == m_id) begin
                    m_has = 1'b0;
                end else begin
                    m_id = id_i;
                    m_data = data_i;
                    m_idle = 0;
                end
            end
        end else if (m_has) begin
            m_idle++;
            if (m_idle == LT) begin
                emit(m_id, m_data, 1'b1);
                m_has = 1'b0;
            end
        end
        exp_lock = m_has;
    endtask

    // Called at posedge+1 with inputs set; checks at negedge, advances to next posedge+1
    task automatic tick();
        logic [11:0] e;
        @(negedge clk_i);
        if (model_on) begin
            chk("ready_o", ready_o, 1);
            chk("valid_o", valid_o, exp_valid);
            chk("lock_o", lock_o, exp_lock);
            chk("fault_detected_o", fault_detected_o, exp_fault);
            if (valid_o) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_item", {needs_retry_o, id_o, data_o}, e);
                end else begin
                    chk("unexpected_out", valid_o, 0);
                end
            end
            model_step();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [2:0] id, input logic [7:0] d);
        valid_i = 1'b1;
        id_i = id;
        data_i = d;
        tick();
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [2:0] id, nid;
        logic [7:0] d;
        int act;

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 0);
        chk("rst_lock_o", lock_o, 0);
        chk("rst_fault", fault_detected_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_id_o", id_o, 0);
        chk("rst_retry", needs_retry_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Pass-through
        enable_i = 1'b0;
        data_i = 8'hA5;
        id_i = 3'd3;
        valid_i = 1'b1;
        ready_i = 1'b1;
        #1;
        chk("pt_valid_o", valid_o, 1);
        chk("pt_data_o", data_o, 8'hA5);
        chk("pt_id_o", id_o, 3);
        chk("pt_retry", needs_retry_o, 0);
        chk("pt_lock", lock_o, 0);
        chk("pt_ready_o", ready_o, 1);
        ready_i = 1'b0;
        #1;
        chk("pt_ready_low", ready_o, 0);
        @(posedge clk_i);
        #1;
        chk("pt_fault", fault_detected_o, 0);
        ready_i = 1'b1;
        valid_i = 1'b0;
        enable_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Checking mode, directed
        model_reset();
        model_on = 1'b1;
        next_id_i = 3'd3;
        send(3'd2, 8'h3C); send(3'd2, 8'h3C); idle(2);
        send(3'd2, 8'h3C); send(3'd2, 8'h3D); idle(2);
        send(3'd5, 8'h41); idle(LT + 2);
        send(3'd6, 8'h10); send(3'd7, 8'h20); send(3'd7, 8'h20); idle(2);
        send(3'd3, 8'h99); idle(2);
        send(3'd1, 8'h01); idle(LT - 1); send(3'd1, 8'h01); idle(2);

        // Randomized item streams
        for (int k = 0; k < 250; k++) begin
            act = $urandom_range(0, 5);
            nid = 3'($urandom_range(0, 7));
            id = 3'($urandom_range(0, 7));
            if (id == nid) id = id + 3'd1;
            d = 8'($urandom_range(0, 255));
            next_id_i = nid;
            case (act)
                0: begin send(id, d); send(id, d); end
                1: begin send(id, d); send(id, d ^ 8'($urandom_range(0, 1))); end
                2: send(id, d);
                3: idle($urandom_range(1, 6));
                4: send(nid, d);
                default: begin send(id, d); send(id + 3'd1, d); end
            endcase
        end
        idle(LT + 4);
        chk("exp_q_drained", exp_q.size(), 0);

        // Output stall, then reset while holding a first copy
        model_on = 1'b0;
        next_id_i = 3'd0;
        valid_i = 1'b1; id_i = 3'd1; data_i = 8'h55;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        id_i = 3'd4; data_i = 8'h11; ready_i = 1'b0;
        #1;
        chk("stall_valid_o", valid_o, 1);
        chk("stall_ready_o", ready_o, 0);
        chk("stall_data_o", data_o, 8'h55);
        chk("stall_id_o", id_o, 1);
        chk("stall_retry", needs_retry_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("hold_valid_o", valid_o, 1);
            chk("hold_ready_o", ready_o, 0);
            chk("hold_data_o", data_o, 8'h55);
            chk("hold_id_o", id_o, 1);
        end
        ready_i = 1'b1;
        #1;
        chk("drain_ready_o", ready_o, 1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        #1;
        chk("drained_valid_o", valid_o, 0);
        chk("wait_lock_o", lock_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid_o", valid_o, 0);
        chk("mid_rst_lock_o", lock_o, 0);
        chk("mid_rst_ready_o", ready_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        model_reset();
        model_on = 1'b1;
        next_id_i = 3'd3;
        idle(1);
        send(3'd2, 8'h77); send(3'd2, 8'h77); idle(LT + 2);
        chk("post_rst_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
